// File: rtl/h14tx_period_scheduler.sv
// HDMI 1.4 TX period sequencer: delays the pixel stream DELAY clocks and schedules control, video
// preamble/guard band/video and, with H14TX_SCHED_ISLAND_EN defined, data island periods.
module h14tx_period_scheduler #(
    parameter int DELAY    = 60,
    parameter int CTRL_MIN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] video_in,
    input  logic        island_req,
    output logic        island_ack,
    output logic [4:0]  island_idx,
    output logic [2:0]  mode,
    output logic [3:0]  ctl,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [23:0] video_out,
    output logic        enc_enable,
    output logic        timing_err
);
    typedef enum logic [2:0] {
        S_CTRL, S_VPRE, S_VGB, S_VIDEO, S_IPRE, S_IGBL, S_ISL, S_IGBT
    } state_t;

    localparam logic [3:0] CMIN = 4'(CTRL_MIN);

    logic [DELAY-1:0]       de_q, de_d;
    logic [DELAY-1:0][25:0] dat_q, dat_d;
    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d, ctrl_q, ctrl_d, ctl_q, ctl_d;
    logic [4:0]             idx_q, idx_d;
    logic                   ack_q, ack_d, enc_q, enc_d, err_q, err_d;
    logic                   ahead_1, vid_edge;

    // de_q[DELAY-1-k] is the de value that reaches the output k cycles from now.
    assign ahead_1  = de_q[DELAY-2];
    // Rising edge 11 cycles out: 8 preamble + 2 guard cycles then land exactly on the first pixel.
    assign vid_edge = de_q[DELAY-12] & ~de_q[DELAY-11];

`ifdef H14TX_SCHED_ISLAND_EN
    logic quiet;
    assign quiet = ~|de_q[DELAY-1 -: 58];
`else
    logic unused_dvi;
    assign unused_dvi = ^{island_req, de_q[DELAY-1]};
`endif

    always_comb begin
        de_d    = {de_q[DELAY-2:0], de_in};
        dat_d   = {dat_q[DELAY-2:0], {hsync_in, vsync_in, video_in}};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ack_d   = 1'b0;
        err_d   = err_q | (vid_edge & (state_q != S_CTRL));
        case (state_q)
            S_CTRL: begin
                if (ahead_1)       state_d = S_VIDEO;
                else if (vid_edge) state_d = S_VPRE;
                else if (ack_q)    state_d = S_IPRE;
`ifdef H14TX_SCHED_ISLAND_EN
                else if (island_req && ctrl_q >= CMIN && quiet) ack_d = 1'b1;
`endif
            end
            S_VPRE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    cnt_d   = '0;
                    state_d = S_VGB;
                end
            end
            S_VGB: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = ahead_1 ? S_VIDEO : S_CTRL;
                end
            end
            S_VIDEO: if (!ahead_1) state_d = S_CTRL;
`ifdef H14TX_SCHED_ISLAND_EN
            S_IPRE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    cnt_d   = '0;
                    state_d = S_IGBL;
                end
            end
            S_IGBL: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_ISL;
                end
            end
            S_ISL: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'd31) state_d = S_IGBT;
            end
            S_IGBT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_CTRL;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = S_CTRL;
            end
        endcase
        ctrl_d = '0;
        if (state_q == S_CTRL && state_d == S_CTRL)
            ctrl_d = (ctrl_q == 4'hF) ? ctrl_q : ctrl_q + 4'd1;
        case (state_d)
            S_VPRE:  ctl_d = 4'b0001;
            S_IPRE:  ctl_d = 4'b0101;
            default: ctl_d = 4'b0000;
        endcase
        enc_d = (state_d == S_VIDEO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q    <= '0;
            dat_q   <= '0;
            state_q <= S_CTRL;
            cnt_q   <= '0;
            ctrl_q  <= CMIN;
            ctl_q   <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            enc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            de_q    <= de_d;
            dat_q   <= dat_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            ctl_q   <= ctl_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            enc_q   <= enc_d;
            err_q   <= err_d;
        end
    end

    assign mode       = state_q;
    assign ctl        = ctl_q;
    assign enc_enable = enc_q;
    assign island_ack = ack_q;
    assign island_idx = idx_q;
    assign timing_err = err_q;
    assign hsync_out  = dat_q[DELAY-1][25];
    assign vsync_out  = dat_q[DELAY-1][24];
    assign video_out  = dat_q[DELAY-1][23:0];
endmodule

// File: tb/tb_h14tx_period_scheduler.sv
// Bench for h14tx_period_scheduler: de patterns are built up front so expected modes are derived by
// looking ahead in the pattern; expectations queue at drive time and are popped at the output.
module tb_h14tx_period_scheduler;
    localparam int DELAY    = 60;
    localparam int CTRL_MIN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, island_req = 1'b0;
    logic [23:0] video_in = '0;
    logic        island_ack, hsync_out, vsync_out, enc_enable, timing_err;
    logic [4:0]  island_idx;
    logic [2:0]  mode;
    logic [3:0]  ctl;
    logic [23:0] video_out;

    h14tx_period_scheduler #(.DELAY(DELAY), .CTRL_MIN(CTRL_MIN)) dut (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .video_in(video_in), .island_req(island_req), .island_ack(island_ack),
        .island_idx(island_idx), .mode(mode), .ctl(ctl), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .video_out(video_out), .enc_enable(enc_enable),
        .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  mode;
        logic [3:0]  ctl;
        logic        chk_ctl;
        logic        enc;
        logic        hs;
        logic        vs;
        logic [23:0] vid;
    } exp_t;
    typedef struct packed {
        logic [2:0] mode;
        logic [4:0] idx;
    } isl_t;

    exp_t sbq[$];
    isl_t iq[$];
    bit   pat[$];
    int   checks = 0, errors = 0;
    int   ncyc, ack_cnt, ack_call, prev_ack, min_gap, last_vid_call, req_from, req_to;
    bit   drop_on_ack;

    // Spec-level view: video where de is high; VPRE/VGB fill the 10 cycles before a rising edge
    // only when the 11 cycles before that edge were all blank, otherwise plain control.
    function automatic logic [2:0] exp_mode(input int i);
        if (pat[i]) return 3'd3;
        for (int d = 1; d <= 10; d++) begin
            if (i + d < pat.size() && pat[i+d]) begin
                for (int j = i + d - 11; j < i + d; j++)
                    if (j >= 0 && pat[j]) return 3'd0;
                return (d <= 2) ? 3'd2 : 3'd1;
            end
        end
        return 3'd0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; video_in = '0;
        island_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sbq.delete(); iq.delete(); pat.delete();
        ncyc = 0; ack_cnt = 0; ack_call = -1; prev_ack = -1; min_gap = 1000000;
        last_vid_call = -1; req_from = 0; req_to = -1; drop_on_ack = 1'b0;
    endtask

    task automatic sample();
        exp_t e;
        isl_t s;
        bit   isl_chk;
        isl_chk = 1'b0;
        if (iq.size() > 0) begin
            s = iq.pop_front();
            isl_chk = 1'b1;
            checks++;
            if (mode !== s.mode || enc_enable !== 1'b0 || (s.mode == 3'd4 && ctl !== 4'b0101) ||
                (s.mode == 3'd6 && island_idx !== s.idx)) begin
                errors++;
                $display("FAIL island_seq cyc %0d: got mode=%0d ctl=%b idx=%0d enc=%b want mode=%0d idx=%0d",
                         ncyc, mode, ctl, island_idx, enc_enable, s.mode, s.idx);
            end
        end
        if (sbq.size() == DELAY) begin
            e = sbq.pop_front();
            checks++;
            if ({hsync_out, vsync_out, video_out} !== {e.hs, e.vs, e.vid} ||
                (!isl_chk && (mode !== e.mode || enc_enable !== e.enc ||
                              (e.chk_ctl && ctl !== e.ctl)))) begin
                errors++;
                $display("FAIL output cyc %0d: got mode=%0d ctl=%b enc=%b hs=%b vs=%b vid=%h want mode=%0d ctl=%b enc=%b hs=%b vs=%b vid=%h",
                         ncyc, mode, ctl, enc_enable, hsync_out, vsync_out, video_out,
                         e.mode, e.ctl, e.enc, e.hs, e.vs, e.vid);
            end
        end
        if (mode === 3'd3) last_vid_call = ncyc;
        if (island_ack === 1'b1) begin
            ack_cnt++;
            if (prev_ack >= 0 && ncyc - prev_ack < min_gap) min_gap = ncyc - prev_ack;
            prev_ack = ncyc;
            ack_call = ncyc;
            for (int k = 0; k < 44; k++) begin
                if (k < 8)       s = '{3'd4, 5'd0};
                else if (k < 10) s = '{3'd5, 5'd0};
                else if (k < 42) s = '{3'd6, 5'(k - 10)};
                else             s = '{3'd7, 5'd0};
                iq.push_back(s);
            end
        end
    endtask

    task automatic run_pattern();
        for (int i = 0; i < pat.size(); i++) begin
            exp_t e;
            int   call;
            call       = ncyc + 1;
            de_in      = pat[i];
            hsync_in   = 1'($urandom);
            vsync_in   = 1'($urandom);
            video_in   = 24'($urandom);
            island_req = (call >= req_from) && (call <= req_to) && !(drop_on_ack && ack_cnt > 0);
            e.mode     = exp_mode(i);
            e.ctl      = (e.mode == 3'd1) ? 4'b0001 : 4'b0000;
            e.chk_ctl  = (e.mode <= 3'd1);
            e.enc      = (e.mode == 3'd3);
            e.hs       = hsync_in;
            e.vs       = vsync_in;
            e.vid      = video_in;
            sbq.push_back(e);
            @(posedge clk);
            #1 ncyc++;
            sample();
        end
    endtask

    task automatic add(input bit v, input int n);
        for (int k = 0; k < n; k++) pat.push_back(v);
    endtask

    task automatic test_reset();
        logic [40:0] o;
        rst_n = 1'b0;
        @(posedge clk);
        #1 o = {island_ack, island_idx, mode, ctl, hsync_out, vsync_out, video_out, enc_enable, timing_err};
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", o);
        end
    endtask

    task automatic test_lines();
        do_reset();
        add(0, 20);
        for (int l = 0; l < 2; l++) begin
            add(1, 1280);
            add(0, 370);
        end
        add(0, DELAY);
        run_pattern();
        checks++;
        if (timing_err !== 1'b0) begin
            errors++;
            $display("FAIL lines_timing_err: got %b want 0", timing_err);
        end
    endtask

    task automatic test_short_gap();
        do_reset();
        add(0, 20); add(1, 200); add(0, 5); add(1, 200); add(0, DELAY + 20);
        run_pattern();
        checks++;
        if (timing_err !== 1'b1) begin
            errors++;
            $display("FAIL gap_timing_err: got %b want 1", timing_err);
        end
        pat.delete();
        add(0, 50);
        run_pattern();
        checks++;
        if (timing_err !== 1'b1) begin
            errors++;
            $display("FAIL gap_err_sticky: got %b want 1", timing_err);
        end
        do_reset();
        checks++;
        if (timing_err !== 1'b0) begin
            errors++;
            $display("FAIL gap_err_reset: got %b want 0", timing_err);
        end
    endtask

    task automatic test_reset_mid_video();
        logic [40:0] o;
        do_reset();
        add(0, 20); add(1, 300);
        run_pattern();
        checks++;
        if (mode !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_mode: got %0d want 3", mode);
        end
        #2 rst_n = 1'b0;
        #1 o = {island_ack, island_idx, mode, ctl, hsync_out, vsync_out, video_out, enc_enable, timing_err};
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", o);
        end
        de_in = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < DELAY; k++) begin
            @(posedge clk);
            #1 checks++;
            if (mode !== 3'd0 || enc_enable !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_ctrl cyc %0d: got mode=%0d enc=%b want 0 0", k, mode, enc_enable);
            end
        end
    endtask

`ifdef H14TX_SCHED_ISLAND_EN
    task automatic test_island();
        do_reset();
        req_from = 1; req_to = 1000000; drop_on_ack = 1'b1;
        add(0, 150);
        run_pattern();
        checks++;
        if (ack_cnt !== 1 || ack_call !== 1) begin
            errors++;
            $display("FAIL island_ack: got count=%0d at=%0d want count=1 at=1", ack_cnt, ack_call);
        end
        drop_on_ack = 1'b0;
        pat.delete();
        add(0, 200);
        run_pattern();
        checks++;
        if (ack_cnt < 3 || min_gap < 44 + CTRL_MIN) begin
            errors++;
            $display("FAIL island_rearm: got acks=%0d min_gap=%0d want >=3 and >=%0d", ack_cnt, min_gap, 44 + CTRL_MIN);
        end
    endtask

    task automatic test_island_blocked();
        do_reset();
        req_from = 110; req_to = 1000000; drop_on_ack = 1'b1;
        add(0, 100); add(1, 100); add(0, 250);
        run_pattern();
        checks++;
        if (ack_cnt !== 1 || ack_call - last_vid_call < CTRL_MIN) begin
            errors++;
            $display("FAIL island_blocked: got acks=%0d ack_at=%0d last_video=%0d want 1 ack >=%0d after video",
                     ack_cnt, ack_call, last_vid_call, CTRL_MIN);
        end
    endtask

    task automatic test_island_vs_video();
        do_reset();
        req_from = 101 + DELAY - 11; req_to = req_from;
        add(0, 100); add(1, 50); add(0, 100);
        run_pattern();
        checks++;
        if (ack_cnt !== 0) begin
            errors++;
            $display("FAIL island_vs_video: got acks=%0d want 0", ack_cnt);
        end
    endtask
`else
    task automatic test_dvi_ignore();
        do_reset();
        req_from = 1; req_to = 1000000;
        add(0, 150);
        run_pattern();
        checks++;
        if (ack_cnt !== 0 || island_idx !== 5'd0) begin
            errors++;
            $display("FAIL dvi_island: got acks=%0d idx=%0d want 0 0", ack_cnt, island_idx);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lines();
        test_short_gap();
        test_reset_mid_video();
`ifdef H14TX_SCHED_ISLAND_EN
        test_island();
        test_island_blocked();
        test_island_vs_video();
`else
        test_dvi_ignore();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
